// File: rtl/door_timer.sv
`default_nettype none
// ============================================================================
//  Module   : door_timer
//  Purpose  : Door sequencer IDLE -> OPENING -> HOLD -> CLOSING -> IDLE,
//             counted down in ticks. Optional macro DOOR_REOPEN_EN lets an
//             open request or obstruction abort a close and reopen the door.
//  Revision : 1.0  initial release
// ============================================================================
module door_timer #(
    parameter int WIDTH  = 4,
    parameter int MOVE_T = 3,
    parameter int HOLD_T = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             open_req,
    input  logic             obstruct,
    output logic [1:0]       door_state,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             closed_done
);

    localparam int MAX_COUNT = (2 ** WIDTH) - 1;

    generate
        if (MOVE_T < 1 || MOVE_T > MAX_COUNT || HOLD_T < 1 || HOLD_T > MAX_COUNT) begin : g_param_check
            $error("door_timer: MOVE_T and HOLD_T must lie in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] C_MOVE = WIDTH'(MOVE_T);
    localparam logic [WIDTH-1:0] C_HOLD = WIDTH'(HOLD_T);
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_OPENING = 2'b01,
        S_HOLD    = 2'b10,
        S_CLOSING = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (open_req) begin
                        state_q <= S_OPENING;
                        rem_q   <= C_MOVE;
                    end
                end
                S_OPENING: begin
                    if (tick) begin
                        if (rem_q > C_ONE) begin
                            rem_q <= rem_q - C_ONE;
                        end else begin
                            state_q <= S_HOLD;
                            rem_q   <= C_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A request or obstruction restarts the dwell even on the expiry tick.
                    if (open_req || obstruct) begin
                        rem_q <= C_HOLD;
                    end else if (tick) begin
                        if (rem_q > C_ONE) begin
                            rem_q <= rem_q - C_ONE;
                        end else begin
                            state_q <= S_CLOSING;
                            rem_q   <= C_MOVE;
                        end
                    end
                end
                S_CLOSING: begin
`ifdef DOOR_REOPEN_EN
                    if (open_req || obstruct) begin
                        state_q <= S_OPENING;
                        rem_q   <= C_MOVE;
                    end else
`endif
                    if (tick) begin
                        if (rem_q > C_ONE) begin
                            rem_q <= rem_q - C_ONE;
                        end else begin
                            state_q <= S_IDLE;
                            rem_q   <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign door_state  = state_q;
    assign remaining   = rem_q;
    assign busy        = (state_q != S_IDLE);
    assign closed_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_door_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_door_timer
//  Purpose  : Self-checking bench for door_timer against an elapsed-tick model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_door_timer;

    localparam int WIDTH  = 4;
    localparam int MOVE_T = 3;
    localparam int HOLD_T = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             open_req = 1'b0;
    logic             obstruct = 1'b0;
    logic [1:0]       door_state;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             closed_done;

    always #5 clk = ~clk;

    door_timer #(
        .WIDTH (WIDTH),
        .MOVE_T(MOVE_T),
        .HOLD_T(HOLD_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .open_req   (open_req),
        .obstruct   (obstruct),
        .door_state (door_state),
        .remaining  (remaining),
        .busy       (busy),
        .closed_done(closed_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0..3 (idle, opening, hold, closing) plus ticks spent in it.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_done    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int phase_len(input int p);
        case (p)
            1, 3:    return MOVE_T;
            2:       return HOLD_T;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_rem();
        return (m_phase == 0) ? 0 : phase_len(m_phase) - m_elapsed;
    endfunction

    task automatic model(input bit r, input bit t, input bit o, input bit ob);
        m_done = 1'b0;
        if (r) begin
            m_phase   = 0;
            m_elapsed = 0;
        end else if (m_phase == 0) begin
            if (o) begin
                m_phase   = 1;
                m_elapsed = 0;
            end
        end else if (m_phase == 2 && (o || ob)) begin
            m_elapsed = 0;
        end
`ifdef DOOR_REOPEN_EN
        else if (m_phase == 3 && (o || ob)) begin
            m_phase   = 1;
            m_elapsed = 0;
        end
`endif
        else if (t) begin
            m_elapsed++;
            if (m_elapsed == phase_len(m_phase)) begin
                m_phase   = (m_phase + 1) % 4;
                m_elapsed = 0;
                m_done    = (m_phase == 0);
            end
        end
    endtask

    task automatic step(input bit r, input bit t, input bit o, input bit ob);
        rst      = r;
        tick     = t;
        open_req = o;
        obstruct = ob;
        @(posedge clk);
        model(r, t, o, ob);
        #1;
        check("door_state",  32'(door_state),  32'(m_phase));
        check("remaining",   32'(remaining),   32'(exp_rem()));
        check("busy",        32'(busy),        32'(m_phase != 0));
        check("closed_done", 32'(closed_done), 32'(m_done));
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);

        // Full cycle with tick held high and a one-cycle open pulse.
        busy_cnt = 0;
        done_cnt = 0;
        step(0, 1, 1, 0);
        busy_cnt += int'(busy);
        repeat (14) begin
            step(0, 1, 0, 0);
            busy_cnt += int'(busy);
            done_cnt += int'(closed_done);
        end
        check("full_cycle_busy_cycles", 32'(busy_cnt), 32'd11);
        check("full_cycle_done_pulses", 32'(done_cnt), 32'd1);

        // Tick paused in HOLD with remaining=3.
        step(0, 1, 1, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        repeat (4) begin
            step(0, 0, 0, 0);
            check("pause_state", 32'(door_state), 32'd2);
            check("pause_rem",   32'(remaining),  32'd3);
        end
        step(0, 1, 0, 0);
        check("resume_rem", 32'(remaining), 32'd2);

        // Obstruction on the HOLD expiry tick reloads the dwell.
        step(0, 1, 0, 0);
        check("hold_last_rem", 32'(remaining), 32'd1);
        step(0, 1, 0, 1);
        check("obstruct_hold_state", 32'(door_state), 32'd2);
        check("obstruct_hold_rem",   32'(remaining),  32'd5);

        // Obstruction in CLOSING with remaining=2.
        repeat (5) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("closing_rem2", 32'(remaining), 32'd2);
        step(0, 1, 0, 1);
`ifdef DOOR_REOPEN_EN
        check("reopen_state", 32'(door_state),  32'd1);
        check("reopen_rem",   32'(remaining),   32'd3);
        check("reopen_done",  32'(closed_done), 32'd0);
`else
        check("noreopen_state", 32'(door_state), 32'd3);
        check("noreopen_rem",   32'(remaining),  32'd1);
        step(0, 1, 0, 0);
        check("noreopen_idle", 32'(door_state),  32'd0);
        check("noreopen_done", 32'(closed_done), 32'd1);
`endif
        repeat (20) step(0, 1, 0, 0);

        // Reset in CLOSING at remaining=1 with open_req asserted.
        step(0, 1, 1, 0);
        repeat (8) step(0, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        check("pre_reset_rem", 32'(remaining), 32'd1);
        step(1, 1, 1, 0);
        check("rst_state", 32'(door_state),  32'd0);
        check("rst_rem",   32'(remaining),   32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(closed_done), 32'd0);
        step(0, 1, 0, 0);
        check("rst_done_after", 32'(closed_done), 32'd0);

        // Randomized traffic, with occasional resets.
        repeat (3000) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/door_timer.md
DOOR_TIMER -- requirements
Module: door_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the countdown register width.
REQ-002 The block SHALL have parameter MOVE_T, default 3, giving door travel time in ticks (open or close).
REQ-003 The block SHALL have parameter HOLD_T, default 5, giving door-open dwell time in ticks.
REQ-004 Port clk: input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst: input, 1, reset; synchronous and active-high.
REQ-006 Port tick: input, 1, countdown enable; each cycle with tick=1 advances the active countdown by one.
REQ-007 Port open_req: input, 1, door-open request (level, sampled every cycle).
REQ-008 Port obstruct: input, 1, doorway obstruction sensor.
REQ-009 Port door_state: output, 2, current state: IDLE=00, OPENING=01, HOLD=10, CLOSING=11.
REQ-010 Port remaining: output, WIDTH, ticks left in the current state.
REQ-011 Port busy: output, 1, high whenever door_state != IDLE.
REQ-012 Port closed_done: output, 1, one-cycle pulse marking completion of a close.

Function
REQ-013 Entering OPENING or CLOSING SHALL load remaining=MOVE_T; entering HOLD SHALL load remaining=HOLD_T; entering IDLE SHALL load remaining=0.
REQ-014 IDLE: open_req=1 SHALL move to OPENING on the next edge, independent of tick.
REQ-015 In OPENING, HOLD and CLOSING, tick=1 with remaining>1 SHALL decrement remaining by 1; tick=1 with remaining==1 SHALL advance to the next state (OPENING->HOLD->CLOSING->IDLE); each such state lasts exactly its loaded number of ticks.
REQ-016 tick=0 SHALL hold state and remaining unchanged, except as required by REQ-014 and REQ-017.
REQ-017 HOLD: open_req=1 or obstruct=1 SHALL reload remaining=HOLD_T on that edge, independent of tick, with priority over expiry.
REQ-018 OPENING: open_req and obstruct SHALL be ignored.
REQ-019 closed_done SHALL be 1 for exactly the one cycle immediately after the CLOSING->IDLE transition, and 0 at all other times.
REQ-020 busy SHALL be derived from door_state in the same cycle, with no added latency.
REQ-021 Elaboration SHALL fail if MOVE_T or HOLD_T is 0 or exceeds 2**WIDTH-1.
REQ-022 remaining SHALL never wrap; it SHALL never decrement below 1 outside IDLE.

Reset
REQ-023 rst=1 SHALL force door_state=IDLE, remaining=0, busy=0 and closed_done=0 on the next edge, from any state.
REQ-024 rst SHALL take priority over open_req, obstruct and tick.
REQ-025 A reset during CLOSING SHALL NOT produce a closed_done pulse.

Configuration
REQ-026 With macro DOOR_REOPEN_EN defined, open_req=1 or obstruct=1 in CLOSING SHALL move to OPENING with remaining=MOVE_T on that edge, independent of tick, with priority over expiry; no closed_done is produced for the aborted close.
REQ-027 Without DOOR_REOPEN_EN, open_req and obstruct SHALL be ignored in CLOSING, and the close SHALL complete normally.

Verification (WIDTH=4, MOVE_T=3, HOLD_T=5)
REQ-028 Setup: tick=1 constant; open_req pulsed for 1 cycle in IDLE. Required response: OPENING for 3 cycles, then HOLD for 5 cycles, then CLOSING for 3 cycles, then IDLE; closed_done high in the first IDLE cycle only; busy high for 11 cycles.
REQ-029 Setup: tick=0 for 4 cycles while in HOLD with remaining=3. Required response: door_state=10 and remaining=3 throughout; countdown resumes at 3 when tick returns to 1.
REQ-030 Setup: obstruct=1 in HOLD on the cycle with remaining=1 and tick=1. Required response: remaining=5 and state stays HOLD.
REQ-031 Setup: obstruct=1 in CLOSING with remaining=2. Required response with DOOR_REOPEN_EN: OPENING with remaining=3 and no closed_done; without the macro: CLOSING continues to IDLE and closed_done pulses.
REQ-032 Setup: rst=1 in CLOSING with remaining=1 and open_req=1. Required response: IDLE, remaining=0, busy=0, and closed_done stays 0.
